// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, state encodings
// and datapath mux select values.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      StRst    = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StMemAdr = 4'd3,
      StMemRd  = 4'd4,
      StMemWb  = 4'd5,
      StMemWr  = 4'd6,
      StExec   = 4'd7,
      StAluWb  = 4'd8,
      StBranch = 4'd9,
      StAddiEx = 4'd10,
      StAddiWb = 4'd11,
      StJump   = 4'd12
   } state_e;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // States that stall on the memory handshake.
   function automatic logic is_wait_state(state_e s);
      return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory stall counter: counts cycles spent waiting in a memory state and flags
// expiry once WAIT_MAX stalls have elapsed without mem_ready.
module mc_wait_timer
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic   clk,
   input  logic   rst_n,
   input  state_e state,
   input  logic   mem_ready,
   input  logic   state_chg,
   output logic   expired
);

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(WAIT_MAX);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             in_wait;

   always_comb begin
      in_wait = is_wait_state(state);
      expired = (WAIT_MAX != 0) && in_wait && !mem_ready && (cnt_q == MaxCnt);
      cnt_d   = cnt_q;
      // With the timeout disabled the counter simply wraps; nothing observes it.
      if (!in_wait || mem_ready || state_chg || expired) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences memory, ALU and register-file
// resources one instruction at a time, with a memory-stall timeout.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       ir_wr,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_wr,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       illegal,
   output logic       bus_err,
   output logic [3:0] state_o
);

   state_e state_d, state_q;
   logic   illegal_d, illegal_q;
   logic   bus_err_d, bus_err_q;
   logic   expired;

   mc_wait_timer #(
      .WAIT_MAX (WAIT_MAX),
      .CNT_W    (CNT_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state_q),
      .mem_ready (mem_ready),
      .state_chg (state_d != state_q),
      .expired   (expired)
   );

   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      bus_err_d = 1'b0;
      case (state_q)
         StRst:    state_d = StFetch;
         StFetch: begin
            if (mem_ready) begin
               state_d = StDecode;
            end else if (expired) begin
               state_d   = StFetch;
               bus_err_d = 1'b1;
            end
         end
         StDecode: begin
            case (op)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_RTYPE:     state_d = StExec;
               OP_BEQ:       state_d = StBranch;
               OP_ADDI:      state_d = StAddiEx;
               OP_J:         state_d = StJump;
               default: begin
                  state_d   = StFetch;
                  illegal_d = 1'b1;
               end
            endcase
         end
         StMemAdr: state_d = (op == OP_LW) ? StMemRd : StMemWr;
         StMemRd: begin
            if (mem_ready) begin
               state_d = StMemWb;
            end else if (expired) begin
               state_d   = StFetch;
               bus_err_d = 1'b1;
            end
         end
         StMemWr: begin
            if (mem_ready) begin
               state_d = StFetch;
            end else if (expired) begin
               state_d   = StFetch;
               bus_err_d = 1'b1;
            end
         end
         StMemWb, StAluWb, StBranch, StAddiWb, StJump: state_d = StFetch;
         StExec:   state_d = StAluWb;
         StAddiEx: state_d = StAddiWb;
         default:  state_d = StRst;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRst;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_wr     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALU_ADD;
      pc_src     = PC_ALU;
      pc_en      = 1'b0;
      case (state_q)
         StFetch: begin
            mem_rd    = 1'b1;
            alu_src_b = SRCB_FOUR;
            // A timed-out fetch must neither load IR nor advance PC.
            ir_wr     = mem_ready;
            pc_en     = mem_ready;
         end
         StDecode: alu_src_b = SRCB_IMM_SH2;
         StMemAdr, StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         StMemRd: begin
            iord   = 1'b1;
            mem_rd = 1'b1;
         end
         StMemWb: begin
            mem_to_reg = 1'b1;
            reg_wr     = 1'b1;
         end
         StMemWr: begin
            iord   = 1'b1;
            mem_wr = 1'b1;
         end
         StExec: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         StAluWb: begin
            reg_dst = 1'b1;
            reg_wr  = 1'b1;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PC_ALUOUT;
            pc_en     = zero;
         end
         StAddiWb: reg_wr = 1'b1;
         StJump: begin
            pc_src = PC_JUMP;
            pc_en  = 1'b1;
         end
         default: ;
      endcase
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: expected per-cycle control words are queued
// with their stimulus and compared as the controller walks each instruction.
module tb_mc_ctrl_fsm;

   typedef struct packed {
      logic [5:0] op;
      logic       mr;
      logic       z;
      logic [3:0] st;
      logic       ill;
      logic       berr;
      logic [3:0] st0;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;

   logic       iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic       pc_en, illegal, bus_err;
   logic [3:0] state_o;

   logic       iord0, mem_rd0, mem_wr0, ir_wr0, reg_dst0, mem_to_reg0, reg_wr0, alu_src_a0;
   logic [1:0] alu_src_b0, alu_op0, pc_src0;
   logic       pc_en0, illegal0, bus_err0;
   logic [3:0] state_o0;

   logic [20:0] obs;
   assign obs = {state_o, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
                 alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal, bus_err};

   int   n_checks = 0;
   int   n_errors = 0;
   ent_t sb_q[$];
   logic [5:0] nxt_op;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.WAIT_MAX(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
      .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
   );

   mc_ctrl_fsm #(.WAIT_MAX(0), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .iord(iord0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .ir_wr(ir_wr0),
      .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0), .reg_wr(reg_wr0),
      .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
      .pc_src(pc_src0), .pc_en(pc_en0), .illegal(illegal0), .bus_err(bus_err0),
      .state_o(state_o0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   // Control word the datapath should see in a given state, from the state table.
   function automatic logic [20:0] exp_word(ent_t e);
      logic iord_e, rd_e, wr_e, irw_e, rdst_e, m2r_e, rw_e, sa_e, pce_e;
      logic [1:0] sb_e, aop_e, pcs_e;
      {iord_e, rd_e, wr_e, irw_e, rdst_e, m2r_e, rw_e, sa_e, pce_e} = '0;
      sb_e = 2'b00; aop_e = 2'b00; pcs_e = 2'b00;
      case (e.st)
         4'd1: begin rd_e = 1; sb_e = 2'b01; irw_e = e.mr; pce_e = e.mr; end
         4'd2: sb_e = 2'b11;
         4'd3, 4'd10: begin sa_e = 1; sb_e = 2'b10; end
         4'd4: begin iord_e = 1; rd_e = 1; end
         4'd5: begin m2r_e = 1; rw_e = 1; end
         4'd6: begin iord_e = 1; wr_e = 1; end
         4'd7: begin sa_e = 1; aop_e = 2'b10; end
         4'd8: begin rdst_e = 1; rw_e = 1; end
         4'd9: begin sa_e = 1; aop_e = 2'b01; pcs_e = 2'b01; pce_e = e.z; end
         4'd11: rw_e = 1;
         4'd12: begin pcs_e = 2'b10; pce_e = 1; end
         default: ;
      endcase
      return {e.st, iord_e, rd_e, wr_e, irw_e, rdst_e, m2r_e, rw_e, sa_e, sb_e, aop_e,
              pcs_e, pce_e, e.ill, e.berr};
   endfunction

   task automatic push(input logic [3:0] st, input logic mr, input logic z,
                       input logic ill, input logic berr, input logic [3:0] st0);
      ent_t e;
      e.op = nxt_op; e.mr = mr; e.z = z; e.st = st; e.ill = ill; e.berr = berr; e.st0 = st0;
      sb_q.push_back(e);
   endtask

   task automatic push_s(input logic [3:0] st);
      push(st, 1'b1, 1'b0, 1'b0, 1'b0, st);
   endtask

   // Entered at a falling edge; drives each entry's inputs and checks mid-low-phase.
   task automatic run_sb();
      ent_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         op = e.op; mem_ready = e.mr; zero = e.z;
         #1;
         chk($sformatf("ctl_st%0d", e.st), 32'(obs), 32'(exp_word(e)));
         chk($sformatf("nto_st%0d", e.st0), 32'({state_o0, bus_err0}), 32'({e.st0, 1'b0}));
         @(negedge clk);
      end
   endtask

   initial begin
      ent_t e;
      rst_n = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0; nxt_op = '0;
      repeat (2) @(negedge clk);
      chk("reset_word", 32'(obs), 32'h0);
      rst_n = 1'b1;

      push_s(4'd0);
      nxt_op = 6'h00; push_s(1); push_s(2); push_s(7); push_s(8);
      nxt_op = 6'h23; push_s(1); push_s(2); push_s(3);
      repeat (3) push(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      push_s(4); push_s(5);
      nxt_op = 6'h2B; push_s(1); push_s(2); push_s(3); push_s(6);
      nxt_op = 6'h04; push_s(1); push_s(2); push(4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
      push_s(1); push_s(2); push(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
      nxt_op = 6'h08; push_s(1); push_s(2); push_s(10); push_s(11);
      nxt_op = 6'h02; push_s(1); push_s(2); push_s(12);
      nxt_op = 6'h3F; push_s(1); push_s(2);
      nxt_op = 6'h02; push(4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1); push_s(2); push_s(12);
      // mem_ready arriving on the would-be timeout cycle is a success.
      nxt_op = 6'h00;
      repeat (4) push(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
      push_s(1); push_s(2); push_s(7); push_s(8);
      nxt_op = 6'h2B; push_s(1); push_s(2); push_s(3);
      repeat (5) push(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
      push(4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6);
      repeat (4) push(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
      push(4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6);
      run_sb();

      rst_n = 1'b0;
      #1;
      chk("rst_hang_st", 32'(state_o0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      nxt_op = 6'h23;
      push_s(0); push_s(1); push_s(2); push_s(3);
      push(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);
      run_sb();
      mem_ready = 1'b0;
      e = '{op: 6'h23, mr: 1'b0, z: 1'b0, st: 4'd4, ill: 1'b0, berr: 1'b0, st0: 4'd4};
      #1;
      chk("memrd_pre_rst", 32'(obs), 32'(exp_word(e)));
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_word", 32'(obs), 32'h0);
      chk("async_rst_st0", 32'(state_o0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_st", 32'(state_o), 32'h0);
      @(negedge clk);
      #1;
      chk("post_rst_fetch", 32'(state_o), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
